tiger_shifter_pipe: RTL and testbench

Parametrised, pipelined barrel shifter for the Tiger datapath. Supports logical/arithmetic shifts and optional rotates, with valid/ready handshakes at both ends and a side-band tag. Sits between the ALU operand latch and the writeback mux, so wide or high-fmax configurations can break the logarithmic shift tree across register stages.

---
 rtl/tiger_shifter_pipe.sv | 151 +++++++++++++++
 tb/tb_tiger_shifter_pipe.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tiger_shifter_pipe.sv
// Pipelined logarithmic barrel shifter with valid/ready at both ends and a pass-through tag.
// Define TIGER_SHIFTER_ROTATE_EN to build ROL/ROR; otherwise those op codes pass data through.
`timescale 1ns/1ps
module tiger_shifter_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2,
    parameter int TAG_W  = 5,
    localparam int L     = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_src,
    input  logic [L-1:0]     in_amt,
    input  logic [2:0]       in_op,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [TAG_W-1:0] out_tag
);

    localparam logic [2:0] OP_SLL = 3'b000;
    localparam logic [2:0] OP_SRL = 3'b001;
    localparam logic [2:0] OP_SRA = 3'b010;
`ifdef TIGER_SHIFTER_ROTATE_EN
    localparam logic [2:0] OP_ROL = 3'b011;
    localparam logic [2:0] OP_ROR = 3'b100;
`endif

    // One layer of the shift tree; sh is a constant at every call site.
    function automatic logic [WIDTH-1:0] f_layer(
        input logic [WIDTH-1:0] d,
        input logic             take,
        input logic [2:0]       op,
        input logic             fill,
        input int               sh
    );
        logic [WIDTH-1:0] r;
        r = d;
        if (take) begin
            case (op)
                OP_SLL: r = d << sh;
                OP_SRL: r = d >> sh;
                OP_SRA: r = (d >> sh) | (fill ? ~({WIDTH{1'b1}} >> sh) : '0);
`ifdef TIGER_SHIFTER_ROTATE_EN
                OP_ROL: r = (d << sh) | (d >> (WIDTH - sh));
                OP_ROR: r = (d >> sh) | (d << (WIDTH - sh));
`endif
                default: r = d;
            endcase
        end
        return r;
    endfunction

    genvar gi, gj;

    for (gi = 0; gi < STAGES; gi++) begin : g_stage
        // Stage gi owns layers FL..FL+NL-1; amt bits below AW_IN are still pending.
        localparam int FL     = (gi * L + STAGES - 1) / STAGES;
        localparam int NL     = ((gi + 1) * L + STAGES - 1) / STAGES - FL;
        localparam int AW_IN  = L - FL;
        localparam int AW_OUT = AW_IN - NL;

        logic              w_vin;
        logic              w_fill;
        logic [AW_IN-1:0]  w_amt;
        logic [2:0]        w_op;
        logic [TAG_W-1:0]  w_tag;
        logic [WIDTH-1:0]  w_din;
        logic [WIDTH-1:0]  w_dout;
        logic              w_adv;

        logic              r_valid;
        logic [WIDTH-1:0]  r_data;
        logic [TAG_W-1:0]  r_tag;

        if (gi == 0) begin : g_in
            assign w_vin  = in_valid;
            assign w_din  = in_src;
            assign w_amt  = in_amt;
            assign w_op   = in_op;
            assign w_fill = in_src[WIDTH-1];
            assign w_tag  = in_tag;
        end else begin : g_prev
            assign w_vin  = g_stage[gi-1].r_valid;
            assign w_din  = g_stage[gi-1].r_data;
            assign w_amt  = g_stage[gi-1].g_ctrl.r_amt;
            assign w_op   = g_stage[gi-1].g_ctrl.r_op;
            assign w_fill = g_stage[gi-1].g_ctrl.r_fill;
            assign w_tag  = g_stage[gi-1].r_tag;
        end

        for (gj = 0; gj < NL; gj++) begin : g_layer
            logic [WIDTH-1:0] w_out;
            if (gj == 0) begin : g_first
                assign w_out = f_layer(w_din, w_amt[AW_IN-1-gj], w_op, w_fill, 1 << (AW_IN - 1 - gj));
            end else begin : g_next
                assign w_out = f_layer(g_layer[gj-1].w_out, w_amt[AW_IN-1-gj], w_op, w_fill,
                                       1 << (AW_IN - 1 - gj));
            end
        end
        assign w_dout = g_layer[NL-1].w_out;

        // A slot may load when it is empty or its occupant moves on this edge.
        if (gi == STAGES - 1) begin : g_adv_last
            assign w_adv = !r_valid || out_ready;
        end else begin : g_adv_mid
            assign w_adv = !r_valid || g_stage[gi+1].w_adv;
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_valid <= 1'b0;
                r_data  <= '0;
                r_tag   <= '0;
            end else if (w_adv) begin
                r_valid <= w_vin;
                if (w_vin) begin
                    r_data <= w_dout;
                    r_tag  <= w_tag;
                end
            end
        end

        if (gi < STAGES - 1) begin : g_ctrl
            logic [AW_OUT-1:0] r_amt;
            logic [2:0]        r_op;
            logic              r_fill;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_amt  <= '0;
                    r_op   <= '0;
                    r_fill <= 1'b0;
                end else if (w_adv && w_vin) begin
                    r_amt  <= w_amt[AW_OUT-1:0];
                    r_op   <= w_op;
                    r_fill <= w_fill;
                end
            end
        end
    end

    assign in_ready  = g_stage[0].w_adv;
    assign out_valid = g_stage[STAGES-1].r_valid;
    assign out_data  = g_stage[STAGES-1].r_data;
    assign out_tag   = g_stage[STAGES-1].r_tag;

endmodule

// File: tb/tb_tiger_shifter_pipe.sv
// Scoreboard bench for tiger_shifter_pipe: directed shifts, backpressure, reset flush,
// plus a random sweep over four width/depth configurations.
`timescale 1ns/1ps
module tb_tiger_shifter_pipe;

    localparam int WIDTH  = 32;
    localparam int STAGES = 2;
    localparam int TAG_W  = 5;
    localparam int L      = 5;
`ifdef TIGER_SHIFTER_ROTATE_EN
    localparam bit ROT = 1'b1;
`else
    localparam bit ROT = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_src = '0;
    logic [L-1:0]     in_amt = '0;
    logic [2:0]       in_op = '0;
    logic [TAG_W-1:0] in_tag = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] out_data;
    logic [TAG_W-1:0] out_tag;

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Bit-by-bit reference: each result bit picks its source bit directly.
    function automatic logic [63:0] ref_shift(input logic [63:0] src, input int amt,
                                              input logic [2:0] op, input int w);
        logic [63:0] r;
        int a;
        r = '0;
        a = amt % w;
        for (int i = 0; i < w; i++) begin
            case (op)
                3'd0: r[i] = (i - a >= 0) ? src[i-a] : 1'b0;
                3'd1: r[i] = (i + a < w) ? src[i+a] : 1'b0;
                3'd2: r[i] = (i + a < w) ? src[i+a] : src[w-1];
                3'd3: r[i] = ROT ? src[(i - a + w) % w] : src[i];
                3'd4: r[i] = ROT ? src[(i + a) % w] : src[i];
                default: r[i] = src[i];
            endcase
        end
        return r;
    endfunction

    tiger_shifter_pipe #(.WIDTH(WIDTH), .STAGES(STAGES), .TAG_W(TAG_W)) u_dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_src    (in_src),
        .in_amt    (in_amt),
        .in_op     (in_op),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag)
    );

    typedef struct packed {
        logic [WIDTH-1:0] d;
        logic [TAG_W-1:0] t;
    } exp_t;

    exp_t             sb_q[$];
    logic [WIDTH-1:0] exp_data = '0;
    int               n_out = 0;
    bit               held_v = 1'b0;
    logic [WIDTH-1:0] held_d;
    logic [TAG_W-1:0] held_t;

    always @(negedge clk) begin
        exp_t e;
        if (!reset_n) begin
            sb_q.delete();
            held_v = 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_out", 64'(out_valid), 64'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("data", 64'(out_data), 64'(e.d));
                    check("tag", 64'(out_tag), 64'(e.t));
                    $display("txn tag=%0d data=%h", out_tag, out_data);
                    n_out++;
                end
            end
            if (out_valid && !out_ready && held_v) begin
                check("hold_data", 64'(out_data), 64'(held_d));
                check("hold_tag", 64'(out_tag), 64'(held_t));
            end
            held_v = out_valid && !out_ready;
            held_d = out_data;
            held_t = out_tag;
            if (in_valid && in_ready) sb_q.push_back('{exp_data, in_tag});
        end
    end

    // Sweep instances: widths 8 and 64, each at STAGES = 1 and STAGES = log2(WIDTH).
    localparam int SW_W [4] = '{8, 8, 64, 64};
    localparam int SW_S [4] = '{1, 3, 1, 6};
    logic        sw_valid = 1'b0;
    logic [63:0] sw_src = '0;
    logic [5:0]  sw_amt = '0;
    logic [2:0]  sw_op = '0;
    int          sw_cnt [4] = '{0, 0, 0, 0};

    genvar gi;
    for (gi = 0; gi < 4; gi++) begin : g_sw
        localparam int W  = SW_W[gi];
        localparam int AW = $clog2(W);
        logic             rdy, ov;
        logic [W-1:0]     od;
        logic [TAG_W-1:0] ot;
        logic [63:0]      q[$];

        tiger_shifter_pipe #(.WIDTH(W), .STAGES(SW_S[gi]), .TAG_W(TAG_W)) u_sw (
            .clk       (clk),
            .reset_n   (reset_n),
            .in_valid  (sw_valid),
            .in_ready  (rdy),
            .in_src    (sw_src[W-1:0]),
            .in_amt    (sw_amt[AW-1:0]),
            .in_op     (sw_op),
            .in_tag    ('0),
            .out_valid (ov),
            .out_ready (1'b1),
            .out_data  (od),
            .out_tag   (ot)
        );

        always @(negedge clk) begin
            logic [63:0] e;
            if (!reset_n) begin
                q.delete();
            end else begin
                if (ov) begin
                    if (q.size() == 0) begin
                        check("sweep_unexpected", 64'(ov), 64'd0);
                    end else begin
                        e = q.pop_front();
                        check($sformatf("sweep_w%0d_s%0d", W, SW_S[gi]), 64'(od), e);
                        sw_cnt[gi]++;
                    end
                end
                if (sw_valid && rdy) q.push_back(ref_shift(sw_src, int'(sw_amt), sw_op, W));
            end
        end
    end

    task automatic load(input logic [WIDTH-1:0] src, input logic [L-1:0] amt, input logic [2:0] op,
                        input logic [TAG_W-1:0] tag, input logic [WIDTH-1:0] exp);
        in_src   = src;
        in_amt   = amt;
        in_op    = op;
        in_tag   = tag;
        exp_data = exp;
        in_valid = 1'b1;
    endtask

    task automatic load_rand(input logic [TAG_W-1:0] tag, input int max_op);
        logic [WIDTH-1:0] s;
        logic [L-1:0]     a;
        logic [2:0]       o;
        s = $urandom;
        a = L'($urandom);
        o = 3'($urandom_range(0, max_op));
        load(s, a, o, tag, WIDTH'(ref_shift(64'(s), int'(a), o, WIDTH)));
    endtask

    // Present one request (called just after a rising edge) and return after it is accepted.
    task automatic send(input logic [WIDTH-1:0] src, input logic [L-1:0] amt, input logic [2:0] op,
                        input logic [TAG_W-1:0] tag, input logic [WIDTH-1:0] exp);
        int guard;
        load(src, amt, op, tag, exp);
        guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) check("accept_timeout", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_lat(input logic [WIDTH-1:0] src, input logic [L-1:0] amt, input logic [2:0] op,
                            input logic [TAG_W-1:0] tag, input logic [WIDTH-1:0] exp);
        int lat;
        send(src, amt, op, tag, exp);
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", 64'(lat), 64'(STAGES));
    endtask

    task automatic wait_empty();
        int g;
        out_ready = 1'b1;
        g = 0;
        while ((sb_q.size() != 0 || out_valid) && g < 200) begin
            @(posedge clk);
            #1;
            g++;
        end
        check("drain", 64'(sb_q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int  idx;
        int  base;
        int  sent;
        int  cyc;
        bit  acc;
        bit  saw_low;

        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_tag", 64'(out_tag), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed shifts with latency measurement on an empty pipe.
        send_lat(32'h8000_0000, 5'd31, 3'b010, 5'd1, 32'hFFFF_FFFF);
        send_lat(32'h8000_0000, 5'd31, 3'b001, 5'd2, 32'h0000_0001);
        send_lat(32'h0000_0001, 5'd31, 3'b000, 5'd3, 32'h8000_0000);
        send(32'h8000_0001, 5'd1, 3'b011, 5'd4, ROT ? 32'h0000_0003 : 32'h8000_0001);
        send(32'h0000_0001, 5'd4, 3'b100, 5'd5, ROT ? 32'h1000_0000 : 32'h0000_0001);
        send(32'hC0DE_1234, 5'd9, 3'b010, 5'd6, 32'hFFE0_6F09);
        for (int op = 0; op < 5; op++) send(32'hA5C3_0F81, 5'd0, 3'(op), 5'(op), 32'hA5C3_0F81);
        for (int op = 5; op < 8; op++) send(32'h1357_9BDF, 5'd7, 3'(op), 5'(op), 32'h1357_9BDF);
        wait_empty();

        // Backpressure: six tagged requests, consumer stalled for cycles 3..7.
        idx = 0;
        base = n_out;
        saw_low = 1'b0;
        for (int c = 0; c < 20; c++) begin
            out_ready = !(c >= 3 && c <= 7);
            if (!in_valid && idx < 6) load_rand(5'(idx), 2);
            @(negedge clk);
            if (in_valid && !in_ready) saw_low = 1'b1;
            acc = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                idx++;
                in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        check("bp_ready_drop", 64'(saw_low), 64'd1);
        check("bp_accepted", 64'(idx), 64'd6);
        wait_empty();
        check("bp_results", 64'(n_out - base), 64'd6);

        // Random stream with random valid and ready.
        sent = 0;
        cyc = 0;
        base = n_out;
        while (sent < 150 && cyc < 4000) begin
            out_ready = ($urandom_range(0, 99) < 65);
            if (!in_valid && $urandom_range(0, 99) < 70) load_rand(5'(sent), 7);
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                sent++;
                in_valid = 1'b0;
            end
            cyc++;
        end
        in_valid = 1'b0;
        check("stream_sent", 64'(sent), 64'd150);
        wait_empty();
        check("stream_results", 64'(n_out - base), 64'd150);

        // Reset with two requests in flight.
        out_ready = 1'b0;
        load_rand(5'd11, 7);
        @(posedge clk);
        #1;
        load_rand(5'd12, 7);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("pre_reset_valid", 64'(out_valid), 64'd1);
        #3 reset_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check("mid_rst_out_data", 64'(out_data), 64'd0);
        check("mid_rst_out_tag", 64'(out_tag), 64'd0);
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("post_rst_no_stale", 64'(out_valid), 64'd0);

        // Sweep over the extra configurations.
        for (int c = 0; c < 300; c++) begin
            sw_valid = 1'b1;
            sw_src   = {$urandom, $urandom};
            sw_amt   = 6'($urandom);
            sw_op    = 3'($urandom_range(0, 7));
            @(posedge clk);
            #1;
        end
        sw_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) check($sformatf("sweep_count_%0d", i), 64'(sw_cnt[i]), 64'd300);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
